// File: rtl/sram_2p_march_bist_pkg.sv
// Shared definitions for the two-port SRAM March BIST controller.
// Holds the controller state encoding and the march element table.
// Each table entry gives the address direction, the op list and the
// port that the element uses.
package sram_2p_march_bist_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One march element.
    // - down:    addresses run from max down to 0.
    // - two_ops: the element is a read followed by a write.
    // - op0_wr:  the first op is a write rather than a read.
    // - op0_val: background of the first op (0 = PATTERN, 1 = ~PATTERN).
    // - op1_val: background of the second op.
    // - port_b:  the element runs on port B instead of port A.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_wr;
        logic op0_val;
        logic op1_val;
        logic port_b;
    } elem_t;

    localparam int unsigned ELEM_W    = 3;
    localparam int unsigned NUM_ELEMS = 7;
    localparam logic [ELEM_W-1:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

    // The march table:
    // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1);
    // E4 down(r1,w0); E5 up(r0); E6 up(r0) on port B
    function automatic elem_t march_elem(input logic [ELEM_W-1:0] idx);
        elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b1, op0_val: 1'b0, op1_val: 1'b0, port_b: 1'b0};
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_val: 1'b1, port_b: 1'b0};
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_val: 1'b0, port_b: 1'b0};
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b0, op1_val: 1'b1, port_b: 1'b0};
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, op0_wr: 1'b0, op0_val: 1'b1, op1_val: 1'b0, port_b: 1'b0};
            3'd5:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_val: 1'b0, op1_val: 1'b0, port_b: 1'b0};
            3'd6:    e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_val: 1'b0, op1_val: 1'b0, port_b: 1'b1};
            default: e = '{down: 1'b0, two_ops: 1'b0, op0_wr: 1'b0, op0_val: 1'b0, op1_val: 1'b0, port_b: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sram_2p_march_bist_if.sv
// Bundle between the March BIST controller and its environment.
// Ports:
// - control: start, busy, done, fail, fail_addr, fail_elem.
// - port A BIST bus: a_bist_en/men/wen/ren/addr/din/bm, plus a_dout read data.
// - port B BIST bus: b_bist_en/men/wen/ren/addr/din/bm, plus b_dout read data.
// Modports:
// - master: the BIST controller.
// - slave:  the requester and macro side.
interface sram_2p_march_bist_if
    import sram_2p_march_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  fail;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [ELEM_W-1:0]     fail_elem;

    logic                  a_bist_en;
    logic                  a_bist_men;
    logic                  a_bist_wen;
    logic                  a_bist_ren;
    logic [ADDR_WIDTH-1:0] a_bist_addr;
    logic [DATA_WIDTH-1:0] a_bist_din;
    logic [DATA_WIDTH-1:0] a_bist_bm;
    logic [DATA_WIDTH-1:0] a_dout;

    logic                  b_bist_en;
    logic                  b_bist_men;
    logic                  b_bist_wen;
    logic                  b_bist_ren;
    logic [ADDR_WIDTH-1:0] b_bist_addr;
    logic [DATA_WIDTH-1:0] b_bist_din;
    logic [DATA_WIDTH-1:0] b_bist_bm;
    logic [DATA_WIDTH-1:0] b_dout;

    modport master (
        input  start, a_dout, b_dout,
        output busy, done, fail, fail_addr, fail_elem,
        output a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm,
        output b_bist_en, b_bist_men, b_bist_wen, b_bist_ren, b_bist_addr, b_bist_din, b_bist_bm
    );

    modport slave (
        output start, a_dout, b_dout,
        input  busy, done, fail, fail_addr, fail_elem,
        input  a_bist_en, a_bist_men, a_bist_wen, a_bist_ren, a_bist_addr, a_bist_din, a_bist_bm,
        input  b_bist_en, b_bist_men, b_bist_wen, b_bist_ren, b_bist_addr, b_bist_din, b_bist_bm
    );
endinterface

// File: rtl/sram_2p_march_bist_addr_gen.sv
// Up/down address counter for the march sequencer.
// Ports:
// - clk, reset: clock and synchronous active-high reset.
// - i_load:      load the element start address.
// - i_load_down: direction of the element being loaded (1 loads all ones, 0 loads zero).
// - i_step:      advance one address in direction i_down.
// - o_addr:      current address.
// - o_addr_nxt:  the address after this edge.
// - o_last:      current address is the final one for direction i_down.
module bist_addr_gen
    import sram_2p_march_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_load_down,
    input  logic                  i_step,
    input  logic                  i_down,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH-1:0] o_addr_nxt,
    output logic                  o_last
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;

    // Next-address selection: load has priority over stepping
    always_comb begin
        o_addr_nxt = r_addr;
        if (i_load) begin
            if (i_load_down) begin
                o_addr_nxt = ADDR_MAX;
            end else begin
                o_addr_nxt = ADDR_MIN;
            end
        end else if (i_step) begin
            if (i_down) begin
                o_addr_nxt = r_addr - ADDR_ONE;
            end else begin
                o_addr_nxt = r_addr + ADDR_ONE;
            end
        end else begin
            o_addr_nxt = r_addr;
        end
    end

    // Address register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= ADDR_MIN;
        end else begin
            r_addr <= o_addr_nxt;
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == ADDR_MIN) : (r_addr == ADDR_MAX);

endmodule

// File: rtl/sram_2p_march_bist.sv
// March C- style BIST controller for a two-port SRAM macro.
// Runs E0..E5 on port A and a final read pass E6 on port B. It issues one
// access per cycle and compares each read one cycle later. The run stops
// on the first mismatch.
// Ports:
// - clk:   sole clock.
// - reset: synchronous active-high reset.
// - bus:   master side of sram_2p_march_bist_if. It carries start, busy,
//          done, fail, fail_addr and fail_elem, both BIST buses, and the
//          macro read data.
module sram_2p_march_bist
    import sram_2p_march_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_2p_march_bist_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    state_e r_state;
    state_e w_state_nxt;

    // Sequencer position: describes the access on the bus this cycle
    logic              r_act;
    logic [ELEM_W-1:0] r_elem;
    logic              r_op;
    logic              r_busy;
    logic              r_done;

    logic              r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [ELEM_W-1:0] r_fail_elem;

    // Read-compare pipeline (one stage, aligned with macro read latency)
    logic                  r_cmp_vld;
    logic                  r_cmp_port;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [ELEM_W-1:0]     r_cmp_elem;

    logic                  r_a_men, r_a_wen, r_a_ren;
    logic [ADDR_WIDTH-1:0] r_a_addr;
    logic [DATA_WIDTH-1:0] r_a_din, r_a_bm;
    logic                  r_b_men, r_b_wen, r_b_ren;
    logic [ADDR_WIDTH-1:0] r_b_addr;
    logic [DATA_WIDTH-1:0] r_b_din, r_b_bm;

    elem_t                 w_cur;
    elem_t                 w_nxt;
    logic                  w_start_acc;
    logic                  w_cur_wr;
    logic                  w_cur_val;
    logic                  w_op_last;
    logic [DATA_WIDTH-1:0] w_cmp_dout;
    logic                  w_mismatch;
    logic                  w_nxt_act;
    logic [ELEM_W-1:0]     w_nxt_elem;
    logic                  w_nxt_op;
    logic                  w_nxt_wr;
    logic [DATA_WIDTH-1:0] w_nxt_data;
    logic                  w_ag_load;
    logic                  w_ag_step;
    logic                  w_ag_last;
    logic [ADDR_WIDTH-1:0] w_ag_addr;
    logic [ADDR_WIDTH-1:0] w_ag_addr_nxt;

    bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ag_load),
        .i_load_down (w_nxt.down),
        .i_step      (w_ag_step),
        .i_down      (w_cur.down),
        .o_addr      (w_ag_addr),
        .o_addr_nxt  (w_ag_addr_nxt),
        .o_last      (w_ag_last)
    );

    assign w_start_acc = (r_state == ST_IDLE) && bus.start;
    assign w_cur       = march_elem(r_elem);
    // The second op of a two-op element is always the write
    assign w_cur_wr    = r_op | w_cur.op0_wr;
    assign w_cur_val   = r_op ? w_cur.op1_val : w_cur.op0_val;
    assign w_op_last   = r_op | ~w_cur.two_ops;
    assign w_cmp_dout  = r_cmp_port ? bus.b_dout : bus.a_dout;
    assign w_mismatch  = (r_state == ST_RUN) && r_cmp_vld && (w_cmp_dout != r_cmp_exp);

    // Sequencer advance: choose the access for the next cycle
    always_comb begin
        w_nxt_act  = 1'b0;
        w_nxt_elem = r_elem;
        w_nxt_op   = r_op;
        w_ag_load  = 1'b0;
        w_ag_step  = 1'b0;
        if (w_start_acc) begin
            w_nxt_act  = 1'b1;
            w_nxt_elem = 3'd0;
            w_nxt_op   = 1'b0;
            w_ag_load  = 1'b1;
        end else if ((r_state == ST_RUN) && r_act && !w_mismatch) begin
            if (!w_op_last) begin
                w_nxt_act = 1'b1;
                w_nxt_op  = 1'b1;
            end else if (!w_ag_last) begin
                w_nxt_act = 1'b1;
                w_nxt_op  = 1'b0;
                w_ag_step = 1'b1;
            end else if (r_elem != LAST_ELEM) begin
                // Wrap straight into the next element with no gap cycle
                w_nxt_act  = 1'b1;
                w_nxt_elem = r_elem + 3'd1;
                w_nxt_op   = 1'b0;
                w_ag_load  = 1'b1;
            end else begin
                w_nxt_act = 1'b0;
            end
        end else begin
            w_nxt_act = 1'b0;
        end
    end

    assign w_nxt      = march_elem(w_nxt_elem);
    assign w_nxt_wr   = (w_nxt_op & w_nxt.two_ops) | w_nxt.op0_wr;
    assign w_nxt_data = ((w_nxt_op ? w_nxt.op1_val : w_nxt.op0_val) == 1'b1) ? ~PATTERN : PATTERN;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Once accesses have stopped, this cycle holds the final compare
                if (w_mismatch || !r_act) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer position, status flags and compare pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_act       <= 1'b0;
            r_elem      <= 3'd0;
            r_op        <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= ADDR_ZERO;
            r_fail_elem <= 3'd0;
            r_cmp_vld   <= 1'b0;
            r_cmp_port  <= 1'b0;
            r_cmp_exp   <= DATA_ZERO;
            r_cmp_addr  <= ADDR_ZERO;
            r_cmp_elem  <= 3'd0;
        end else begin
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_act      <= w_nxt_act;
            r_elem     <= w_nxt_elem;
            r_op       <= w_nxt_op;
            r_cmp_vld  <= r_act && !w_cur_wr;
            r_cmp_port <= w_cur.port_b;
            r_cmp_exp  <= w_cur_val ? ~PATTERN : PATTERN;
            r_cmp_addr <= w_ag_addr;
            r_cmp_elem <= r_elem;
            if (w_start_acc) begin
                r_fail      <= 1'b0;
                r_fail_addr <= ADDR_ZERO;
                r_fail_elem <= 3'd0;
            end else if (w_mismatch) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_cmp_addr;
                r_fail_elem <= r_cmp_elem;
            end
        end
    end

    // Macro port drivers: address/data hold when the port is idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_men  <= 1'b0;
            r_a_wen  <= 1'b0;
            r_a_ren  <= 1'b0;
            r_a_addr <= ADDR_ZERO;
            r_a_din  <= DATA_ZERO;
            r_a_bm   <= DATA_ZERO;
            r_b_men  <= 1'b0;
            r_b_wen  <= 1'b0;
            r_b_ren  <= 1'b0;
            r_b_addr <= ADDR_ZERO;
            r_b_din  <= DATA_ZERO;
            r_b_bm   <= DATA_ZERO;
        end else begin
            r_a_men <= w_nxt_act && !w_nxt.port_b;
            r_a_wen <= w_nxt_act && !w_nxt.port_b && w_nxt_wr;
            r_a_ren <= w_nxt_act && !w_nxt.port_b && !w_nxt_wr;
            r_b_men <= w_nxt_act && w_nxt.port_b;
            r_b_wen <= w_nxt_act && w_nxt.port_b && w_nxt_wr;
            r_b_ren <= w_nxt_act && w_nxt.port_b && !w_nxt_wr;
            if (w_nxt_act && !w_nxt.port_b) begin
                r_a_addr <= w_ag_addr_nxt;
                if (w_nxt_wr) begin
                    r_a_din <= w_nxt_data;
                    r_a_bm  <= DATA_ONES;
                end
            end
            if (w_nxt_act && w_nxt.port_b) begin
                r_b_addr <= w_ag_addr_nxt;
                if (w_nxt_wr) begin
                    r_b_din <= w_nxt_data;
                    r_b_bm  <= DATA_ONES;
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fail        = r_fail;
    assign bus.fail_addr   = r_fail_addr;
    assign bus.fail_elem   = r_fail_elem;
    assign bus.a_bist_en   = r_busy;
    assign bus.a_bist_men  = r_a_men;
    assign bus.a_bist_wen  = r_a_wen;
    assign bus.a_bist_ren  = r_a_ren;
    assign bus.a_bist_addr = r_a_addr;
    assign bus.a_bist_din  = r_a_din;
    assign bus.a_bist_bm   = r_a_bm;
    assign bus.b_bist_en   = r_busy;
    assign bus.b_bist_men  = r_b_men;
    assign bus.b_bist_wen  = r_b_wen;
    assign bus.b_bist_ren  = r_b_ren;
    assign bus.b_bist_addr = r_b_addr;
    assign bus.b_bist_din  = r_b_din;
    assign bus.b_bist_bm   = r_b_bm;

endmodule

// File: tb/tb_sram_2p_march_bist.sv
// Self-checking bench for sram_2p_march_bist.
// A 256x32 two-port memory model serves the DUT and can inject faults.
// Each run scenario is one row of a vector table.
module tb_sram_2p_march_bist;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_2p_march_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_2p_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PATTERN(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model.
    // - Fault 1: bit 5 of address 0x3C is stuck at 1.
    // - Fault 2: a port-B read of 0xFF returns 1.
    logic [DW-1:0] mem [0:255];
    int fault_mode = 0;

    function automatic logic [DW-1:0] rd_val(input logic port_b, input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem[a];
        if (fault_mode == 1 && a == 8'h3C) d = d | 32'h0000_0020;
        if (fault_mode == 2 && port_b && a == 8'hFF) d = 32'h0000_0001;
        return d;
    endfunction

    always @(posedge clk) begin
        if (bus.a_bist_men && bus.a_bist_wen)
            mem[bus.a_bist_addr] <= (mem[bus.a_bist_addr] & ~bus.a_bist_bm) | (bus.a_bist_din & bus.a_bist_bm);
        if (bus.b_bist_men && bus.b_bist_wen)
            mem[bus.b_bist_addr] <= (mem[bus.b_bist_addr] & ~bus.b_bist_bm) | (bus.b_bist_din & bus.b_bist_bm);
        if (bus.a_bist_men && bus.a_bist_ren) bus.a_dout <= rd_val(1'b0, bus.a_bist_addr);
        if (bus.b_bist_men && bus.b_bist_ren) bus.b_dout <= rd_val(1'b1, bus.b_bist_addr);
    end

    typedef struct {
        string      name;
        int         fault;
        int         rst_cyc;
        int         start2_cyc;
        int         exp_done;
        logic       exp_fail;
        logic [7:0] exp_addr;
        logic [2:0] exp_elem;
        bit         chk_seq;
    } vec_t;

    vec_t vecs[6];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [223:0] ctl_snapshot();
        return {bus.a_bist_en, bus.a_bist_men, bus.a_bist_wen, bus.a_bist_ren, bus.a_bist_addr,
                bus.a_bist_din, bus.a_bist_bm,
                bus.b_bist_en, bus.b_bist_men, bus.b_bist_wen, bus.b_bist_ren, bus.b_bist_addr,
                bus.b_bist_din, bus.b_bist_bm, bus.busy, bus.done, 18'd0};
    endfunction

    task automatic run_vec(input vec_t v);
        int done_cnt = 0;
        int done_cyc = 0;
        int busy_err = 0;
        int seq_err  = 0;
        int exp_end;
        logic [7:0] ea;
        logic       er;
        logic       eb;
        fault_mode = v.fault;
        exp_end = (v.exp_done != 0) ? v.exp_done : v.rst_cyc + 1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 2830; cyc++) begin
            @(negedge clk);
            eb = (cyc < exp_end);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (bus.busy !== eb || bus.a_bist_en !== eb || bus.b_bist_en !== eb) busy_err++;
            if (v.chk_seq && cyc == 1)
                check({v.name, " first access"}, {bus.a_bist_men, bus.a_bist_wen, bus.a_bist_ren,
                      bus.a_bist_addr, bus.a_bist_din, bus.a_bist_bm},
                      {1'b1, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 32'hFFFF_FFFF});
            if (v.chk_seq && cyc >= 1281 && cyc <= 1792) begin
                ea = 8'(255 - (cyc - 1281) / 2);
                er = ((cyc - 1281) % 2) == 0;
                if (!(bus.a_bist_men === 1'b1 && bus.a_bist_ren === er && bus.a_bist_wen === !er &&
                      bus.a_bist_addr === ea && (er || bus.a_bist_din === 32'hFFFF_FFFF) &&
                      bus.b_bist_men === 1'b0))
                    seq_err++;
            end
            if (v.chk_seq && cyc == 2816)
                check({v.name, " last B read"}, {bus.a_bist_men, bus.b_bist_men, bus.b_bist_ren,
                      bus.b_bist_wen, bus.b_bist_addr}, {1'b0, 1'b1, 1'b1, 1'b0, 8'hFF});
            if (v.chk_seq && cyc == 2817)
                check({v.name, " no access after end"}, {bus.a_bist_men, bus.b_bist_men}, 2'b00);
            bus.start = (v.start2_cyc != 0 && cyc == v.start2_cyc) ? 1'b1 : 1'b0;
            if (v.rst_cyc != 0 && cyc == v.rst_cyc) reset = 1'b1;
            if (v.rst_cyc != 0 && cyc == v.rst_cyc + 1) begin
                check({v.name, " controls after reset"}, 64'(ctl_snapshot() != 224'd0), 64'd0);
                reset = 1'b0;
            end
        end
        check({v.name, " done pulses"}, done_cnt, (v.exp_done != 0) ? 1 : 0);
        check({v.name, " done cycle"}, done_cyc, v.exp_done);
        check({v.name, " busy/en window errors"}, busy_err, 0);
        check({v.name, " fail"}, bus.fail, v.exp_fail);
        check({v.name, " fail_addr"}, bus.fail_addr, v.exp_addr);
        check({v.name, " fail_elem"}, bus.fail_elem, v.exp_elem);
        if (v.chk_seq) check({v.name, " E3 sequence errors"}, seq_err, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        vecs[0] = '{"pass",       0, 0,   0,  2818, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[1] = '{"start2",     0, 0,   10, 2818, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[2] = '{"stuck3C",    1, 0,   0,  379,  1'b1, 8'h3C, 3'd1, 1'b0};
        vecs[3] = '{"portB_FF",   2, 0,   0,  2818, 1'b1, 8'hFF, 3'd6, 1'b0};
        vecs[4] = '{"reset600",   0, 600, 0,  0,    1'b0, 8'h00, 3'd0, 1'b0};
        vecs[5] = '{"after_rst",  0, 0,   0,  2818, 1'b0, 8'h00, 3'd0, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset fail", bus.fail, 1'b0);
        check("reset fail_addr", bus.fail_addr, 8'h00);
        check("reset fail_elem", bus.fail_elem, 3'd0);
        check("reset controls", 64'(ctl_snapshot() != 224'd0), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle without start", {bus.busy, bus.a_bist_men, bus.b_bist_men}, 3'b000);
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
